// File: rtl/launcher_pkg.sv
// Shared types and constants for the run launcher.
// State encoding, default counter width and run index width.
package launcher_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int IDX_W     = 4;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        DRAIN,
        FINISH
    } state_t;

endpackage

// File: rtl/run_launcher_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter
    import launcher_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count
);

    // count up while enabled, stick at the top value
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/run_launcher.sv
// Launches a batch of runs on a processor and times each one.
// Optional max-latency tracking: define RUN_LAUNCHER_STATS_EN.
module run_launcher
    import launcher_pkg::*;
#(
    parameter int               CNT_W          = CNT_W_DEF,
    parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = CNT_W'(4095)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       num_runs,
    output logic             req,
    input  logic             done,
    output logic             busy,
    output logic             batch_done,
    output logic [3:0]       run_idx,
    output logic [CNT_W-1:0] cycle_count,
    output logic             timeout,
    output logic [CNT_W-1:0] max_cycles
);

    state_t           state;
    logic [IDX_W-1:0] runs_total;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_inc;
    logic             cnt_clear;
    logic             cnt_en;
    logic             complete;
    logic             expire;
    logic             accept;

    assign cnt_clear = (state == LAUNCH);
    assign cnt_en    = (state == WAIT);
    assign accept    = (state == IDLE) && start;
    assign complete  = (state == WAIT) && done;
    assign expire    = (state == WAIT) && !done &&
                       (count == TIMEOUT_CYCLES - CNT_W'(1));

    // latency of a run finishing now; the counter lags by one
    assign count_inc = (count == '1) ? count : count + CNT_W'(1);

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_run_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .count  (count)
    );

    // batch sequencing with registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            req         <= 1'b0;
            busy        <= 1'b0;
            batch_done  <= 1'b0;
            run_idx     <= '0;
            cycle_count <= '0;
            timeout     <= 1'b0;
            runs_total  <= '0;
        end else begin
            req        <= 1'b0;
            batch_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        busy       <= 1'b1;
                        run_idx    <= '0;
                        timeout    <= 1'b0;
                        runs_total <= num_runs;
                        if (num_runs != '0) begin
                            state <= LAUNCH;
                            req   <= 1'b1;
                        end else begin
                            state      <= FINISH;
                            batch_done <= 1'b1;
                        end
                    end
                end
                LAUNCH: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (complete) begin
                        cycle_count <= count_inc;
                        state       <= DRAIN;
                    end else if (expire) begin
                        timeout    <= 1'b1;
                        state      <= FINISH;
                        batch_done <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (!done) begin
                        if ((run_idx + 4'd1) != runs_total) begin
                            run_idx <= run_idx + 4'd1;
                            state   <= LAUNCH;
                            req     <= 1'b1;
                        end else begin
                            state      <= FINISH;
                            batch_done <= 1'b1;
                        end
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef RUN_LAUNCHER_STATS_EN
    // largest run latency seen in the current batch
    always_ff @(posedge clk) begin
        if (!reset) begin
            max_cycles <= '0;
        end else if (accept) begin
            max_cycles <= '0;
        end else if (complete && (count_inc > max_cycles)) begin
            max_cycles <= count_inc;
        end
    end
`else
    logic unused_accept;
    assign unused_accept = accept;
    assign max_cycles    = '0;
`endif

endmodule

// File: tb/tb_run_launcher.sv
// Scoreboard bench for run_launcher with a processor model.
// Expected max_cycles follows RUN_LAUNCHER_STATS_EN.
module tb_run_launcher;

    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  num_runs;
    logic        req;
    logic        done;
    logic        busy;
    logic        batch_done;
    logic [3:0]  run_idx;
    logic [15:0] cycle_count;
    logic        timeout;
    logic [15:0] max_cycles;

    typedef struct {
        bit          is_bd;
        int          cyc;
        logic [3:0]  idx;
        bit          chk_cc;
        logic [15:0] cc;
        bit          to;
        logic [15:0] mx;
    } exp_t;

    exp_t exp_q[$];
    int   lat_q[$];
    int   hold_q[$];
    int   passed = 0;
    int   total  = 0;
    int   cyc    = 0;
    int   last_cc = 0;

    run_launcher #(
        .CNT_W          (16),
        .TIMEOUT_CYCLES (16'(TO))
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .num_runs    (num_runs),
        .req         (req),
        .done        (done),
        .busy        (busy),
        .batch_done  (batch_done),
        .run_idx     (run_idx),
        .cycle_count (cycle_count),
        .timeout     (timeout),
        .max_cycles  (max_cycles)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d",
                      name, act, exp);
    endtask

    // monitor: pop and compare on every req or batch_done pulse
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (req || batch_done) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_pulse: req=%0b bd=%0b cyc=%0d",
                             req, batch_done, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("kind_bd", {31'd0, batch_done}, {31'd0, e.is_bd});
                    check("pulse_cycle", cyc, e.cyc);
                    check("run_idx", {28'd0, run_idx}, {28'd0, e.idx});
                    check("busy_high", {31'd0, busy}, 32'd1);
                    if (e.chk_cc)
                        check("cycle_count", {16'd0, cycle_count},
                              {16'd0, e.cc});
                    if (e.is_bd) begin
                        check("timeout", {31'd0, timeout}, {31'd0, e.to});
                        check("max_cycles", {16'd0, max_cycles},
                              {16'd0, e.mx});
                    end
                end
            end
        end
    end

    // processor model: done rises lat cycles after req, held hold more
    initial begin
        int l;
        int h;
        done = 1'b0;
        forever begin
            @(negedge clk);
            if (req) begin
                l = (lat_q.size() != 0) ? lat_q.pop_front() : 0;
                h = (hold_q.size() != 0) ? hold_q.pop_front() : 0;
                if (l > 0) begin
                    repeat (l) @(negedge clk);
                    done = 1'b1;
                    repeat (1 + h) @(negedge clk);
                    done = 1'b0;
                end
            end
        end
    end

    task automatic push_exp(input bit is_bd, input int c,
                            input int idx, input bit chk,
                            input int cc, input bit to,
                            input int mx);
        exp_t e;
        e.is_bd  = is_bd;
        e.cyc    = c;
        e.idx    = 4'(idx);
        e.chk_cc = chk;
        e.cc     = 16'(cc);
        e.to     = to;
        e.mx     = 16'(mx);
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        int budget = 400;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        total++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL %s_drain: %0d pending expected 0",
                      name, exp_q.size());
        exp_q.delete();
    endtask

    // lat 0 means done never rises, so that run times out
    task automatic run_batch(input string name, input int n,
                             input int lats[3], input int holds[3],
                             input bit spurious);
        int t;
        int mx = 0;
        @(negedge clk);
        t = cyc + 1;
        if (n == 0) push_exp(1, t, 0, 1, last_cc, 0, 0);
        for (int k = 0; k < n; k++) begin
            push_exp(0, t, k, k > 0, (k > 0) ? lats[(k + 2) % 3] : 0,
                     0, 0);
            lat_q.push_back(lats[k]);
            hold_q.push_back(holds[k]);
            if (lats[k] == 0) begin
                push_exp(1, t + TO + 1, k, 1, last_cc, 1, mx);
                break;
            end
            if (lats[k] > mx) mx = lats[k];
`ifndef RUN_LAUNCHER_STATS_EN
            mx = 0;
`endif
            last_cc = lats[k];
            if (k == n - 1)
                push_exp(1, t + lats[k] + holds[k] + 2, k, 1,
                         last_cc, 0, mx);
            else
                t = t + lats[k] + holds[k] + 2;
        end
        num_runs = 4'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (spurious) begin
            repeat (3) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_drain(name);
        @(negedge clk);
        check({name, "_busy_low"}, {31'd0, busy}, 32'd0);
        check({name, "_req_low"}, {31'd0, req}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: sim time expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        num_runs = 4'd0;
        repeat (3) @(negedge clk);
        check("rst_req", {31'd0, req}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_bd", {31'd0, batch_done}, 32'd0);
        check("rst_idx", {28'd0, run_idx}, 32'd0);
        check("rst_cc", {16'd0, cycle_count}, 32'd0);
        check("rst_to", {31'd0, timeout}, 32'd0);
        check("rst_max", {16'd0, max_cycles}, 32'd0);
        reset = 1'b1;

        run_batch("three7", 3, '{7, 7, 7}, '{0, 0, 0}, 1'b1);
        run_batch("stats", 3, '{4, 9, 6}, '{0, 0, 0}, 1'b0);
        run_batch("drain", 2, '{5, 3, 0}, '{5, 0, 0}, 1'b0);
        run_batch("tmo", 2, '{0, 0, 0}, '{0, 0, 0}, 1'b0);
        run_batch("zero", 0, '{0, 0, 0}, '{0, 0, 0}, 1'b0);

        // abort mid-WAIT of run 1
        @(negedge clk);
        push_exp(0, cyc + 1, 0, 0, 0, 0, 0);
        push_exp(0, cyc + 1 + 5, 1, 1, 3, 0, 0);
        lat_q.push_back(3);
        hold_q.push_back(0);
        lat_q.push_back(0);
        hold_q.push_back(0);
        num_runs = 4'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain("abort");
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("ab_req", {31'd0, req}, 32'd0);
        check("ab_busy", {31'd0, busy}, 32'd0);
        check("ab_bd", {31'd0, batch_done}, 32'd0);
        check("ab_idx", {28'd0, run_idx}, 32'd0);
        check("ab_cc", {16'd0, cycle_count}, 32'd0);
        check("ab_to", {31'd0, timeout}, 32'd0);
        check("ab_max", {16'd0, max_cycles}, 32'd0);
        reset = 1'b1;
        last_cc = 0;
        repeat (4) @(negedge clk);

        run_batch("after", 1, '{2, 0, 0}, '{0, 0, 0}, 1'b0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
